// File: rtl/pim_axis_seq.sv
// PIM instruction front end: AXI-Stream instruction FIFO, repeat expander with a paced
// issue gap, and a back-pressured command output. Optional counters: `PIM_PERF_CNT_EN.
module pim_axis_seq #(
    parameter int INSTR_W    = 64,
    parameter int CMD_W      = 34,
    parameter int ROW_W      = 10,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enable,
    input  logic [GAP_W-1:0]   i_cfg_gap,
    input  logic [ROW_W-1:0]   i_cfg_stride,
    input  logic [INSTR_W-1:0] i_s_axis_tdata,
    input  logic               i_s_axis_tvalid,
    output logic               o_s_axis_tready,
    output logic [CMD_W-1:0]   o_m_axis_tdata,
    output logic               o_m_axis_tvalid,
    input  logic               i_m_axis_tready,
    output logic               o_busy,
    output logic [31:0]        o_perf_cmd_cnt,
    output logic [31:0]        o_perf_stall_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 8 + CMD_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    logic [ENT_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]   r_wr_ptr, r_rd_ptr;
    state_t           r_state;
    logic [CMD_W-1:0] r_cmd;
    logic [7:0]       r_rep_left;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_last;
    logic [CMD_W-1:0] r_tdata;
    logic             r_tvalid;

    logic             w_empty, w_full, w_push, w_pop, w_out_free;
    logic [ENT_W-1:0] w_head;
    logic             w_unused_bits;

    // Only REP and the base command are kept; the gap bits between them are dropped.
    assign w_unused_bits = ^i_s_axis_tdata[INSTR_W-9:CMD_W];

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head     = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign w_push     = i_s_axis_tvalid & o_s_axis_tready;
    assign w_pop      = (r_state == S_IDLE) & ~w_empty & i_enable;
    assign w_out_free = ~r_tvalid | i_m_axis_tready;

    assign o_s_axis_tready = rst_n & i_enable & ~w_full;
    assign o_m_axis_tdata  = r_tdata;
    assign o_m_axis_tvalid = r_tvalid;
    assign o_busy          = ~w_empty | (r_state != S_IDLE) | r_tvalid;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= {i_s_axis_tdata[INSTR_W-1 -: 8], i_s_axis_tdata[CMD_W-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (!i_enable) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= '0;
            r_rep_left <= '0;
            r_gap_cnt  <= '0;
            r_last     <= 1'b0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
        end else if (!i_enable) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b0;
            r_tvalid <= 1'b0;
        end else begin
            if (r_tvalid && i_m_axis_tready)
                r_tvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd      <= w_head[CMD_W-1:0];
                        r_rep_left <= w_head[ENT_W-1 -: 8];
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_out_free) begin
                        r_tdata   <= r_cmd;
                        r_tvalid  <= 1'b1;
                        r_last    <= (r_rep_left == 8'd0);
                        r_gap_cnt <= i_cfg_gap - GAP_W'(1);
                        if (r_rep_left != 8'd0) begin
                            r_cmd[ROW_W-1:0] <= r_cmd[ROW_W-1:0] + i_cfg_stride;
                            r_rep_left       <= r_rep_left - 8'd1;
                        end
                        // A zero gap bypasses S_GAP so commands can launch back to back.
                        if (i_cfg_gap != '0)
                            r_state <= S_GAP;
                        else if (r_rep_left == 8'd0)
                            r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == '0)
                        r_state <= r_last ? S_IDLE : S_ISSUE;
                    else
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PIM_PERF_CNT_EN
    logic [31:0] r_perf_cmd_cnt, r_perf_stall_cnt;

    // Counters freeze while disabled and saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_cmd_cnt   <= '0;
            r_perf_stall_cnt <= '0;
        end else if (i_enable) begin
            if (r_tvalid && i_m_axis_tready && (r_perf_cmd_cnt != 32'hFFFF_FFFF))
                r_perf_cmd_cnt <= r_perf_cmd_cnt + 32'd1;
            if (r_tvalid && !i_m_axis_tready && (r_perf_stall_cnt != 32'hFFFF_FFFF))
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
        end
    end

    assign o_perf_cmd_cnt   = r_perf_cmd_cnt;
    assign o_perf_stall_cnt = r_perf_stall_cnt;
`else
    assign o_perf_cmd_cnt   = 32'd0;
    assign o_perf_stall_cnt = 32'd0;
`endif

endmodule
